// File: rtl/mc_control_if.sv
// Memory handshake between the multi-cycle control unit and the unified memory.
// The controller drives request, write enable and address select; memory answers with ack.
interface mc_control_if;
  logic mem_req;
  logic mem_we;
  logic iord;
  logic mem_ack;

  modport master (output mem_req, output mem_we, output iord, input mem_ack);
  modport slave  (input mem_req, input mem_we, input iord, output mem_ack);
endinterface

// File: rtl/mc_control.sv
// Multi-cycle MIPS control unit: Moore FSM sequencing PC/IR/regfile/ALU/memory,
// with memory-timeout and illegal-opcode traps plus cycle/retired counters.
module mc_control #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr,
  input  logic             alu_zero,
  mc_control_if.master     mem,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_op,
  output logic             ext_op,
  output logic             reg_write,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic [3:0]       state,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_EXEC_R = 4'd2,  S_EXEC_I = 4'd3,
    S_ADDR   = 4'd4,  S_MEM_RD = 4'd5,  S_MEM_WR = 4'd6,  S_WB_R   = 4'd7,
    S_WB_I   = 4'd8,  S_WB_MEM = 4'd9,  S_BRANCH = 4'd10, S_JUMP   = 4'd11,
    S_TRAP   = 4'd15
  } state_t;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       ext_op;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
  } ctl_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J   = 6'h02, OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE = 6'h05, OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C, OP_ORI = 6'h0D, OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B, FN_JR  = 6'h08;

  localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3, ALU_SLT = 3'd4, ALU_SLL = 3'd5;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1, CAUSE_TIMEOUT = 2'd2;
  localparam logic [TO_W-1:0] TIMEOUT_LIMIT = TO_W'(MEM_TIMEOUT);

  state_t          state_reg, state_next;
  ctl_t            ctl_reg;
  logic [TO_W-1:0] wait_reg;
  logic [1:0]      cause_reg, cause_next;
  logic [CNT_W-1:0] cycle_reg, instr_cnt_reg;
  logic            timeout_hit, retire;

  wire [5:0] opcode = instr[31:26];
  wire [5:0] funct  = instr[5:0];
  wire       unused_instr_bits = ^instr[25:6];

  function automatic logic [2:0] r_alu_op(input logic [5:0] fn);
    case (fn)
      6'h20:   return ALU_ADD;
      6'h22:   return ALU_SUB;
      6'h24:   return ALU_AND;
      6'h25:   return ALU_OR;
      6'h2A:   return ALU_SLT;
      6'h00:   return ALU_SLL;
      default: return ALU_ADD;
    endcase
  endfunction

  function automatic state_t dispatch(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      OP_RTYPE: begin
        if (fn == FN_JR) return S_JUMP;
        case (fn)
          6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00: return S_EXEC_R;
          default:                                  return S_TRAP;
        endcase
      end
      OP_LW, OP_SW:             return S_ADDR;
      OP_BEQ, OP_BNE:           return S_BRANCH;
      OP_ADDI, OP_ANDI, OP_ORI: return S_EXEC_I;
      OP_J, OP_JAL:             return S_JUMP;
      default:                  return S_TRAP;
    endcase
  endfunction

  // Control word for a state; instr is stable from DECODE onward, so states
  // that depend on it are always entered with a valid IR.
  function automatic ctl_t moore_ctl(input state_t s, input logic [31:0] ins);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH:  begin c.mem_req = 1'b1; c.alu_src_b = 2'd1; end
      S_DECODE: begin c.alu_src_b = 2'd3; c.ext_op = 1'b1; end
      S_EXEC_R: begin c.alu_src_a = 1'b1; c.alu_op = r_alu_op(ins[5:0]); end
      S_WB_R:   begin c.reg_write = 1'b1; c.reg_dst = 2'd1; end
      S_EXEC_I: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'd2;
        c.ext_op    = (ins[31:26] == OP_ADDI);
        c.alu_op    = (ins[31:26] == OP_ANDI) ? ALU_AND :
                      (ins[31:26] == OP_ORI)  ? ALU_OR  : ALU_ADD;
      end
      S_WB_I:   c.reg_write = 1'b1;
      S_ADDR:   begin c.alu_src_a = 1'b1; c.alu_src_b = 2'd2; c.ext_op = 1'b1; end
      S_MEM_RD: begin c.mem_req = 1'b1; c.iord = 1'b1; end
      S_MEM_WR: begin c.mem_req = 1'b1; c.iord = 1'b1; c.mem_we = 1'b1; end
      S_WB_MEM: begin c.reg_write = 1'b1; c.mem_to_reg = 2'd1; end
      S_BRANCH: begin c.alu_src_a = 1'b1; c.alu_op = ALU_SUB; c.pc_src = 2'd1; end
      S_JUMP: begin
        c.pc_src = (ins[31:26] == OP_RTYPE) ? 2'd3 : 2'd2;
        if (ins[31:26] == OP_JAL) begin
          c.reg_write  = 1'b1;
          c.reg_dst    = 2'd2;
          c.mem_to_reg = 2'd2;
        end
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // An ack arriving on the limit cycle completes the access instead of trapping.
  assign timeout_hit = (MEM_TIMEOUT != 0) && ctl_reg.mem_req && !mem.mem_ack &&
                       (wait_reg == TIMEOUT_LIMIT);

  always_comb begin
    state_next = state_reg;
    cause_next = CAUSE_ILLEGAL;
    case (state_reg)
      S_FETCH: begin
        if (mem.mem_ack)      state_next = S_DECODE;
        else if (timeout_hit) begin state_next = S_TRAP; cause_next = CAUSE_TIMEOUT; end
      end
      S_DECODE: state_next = dispatch(opcode, funct);
      S_EXEC_R: state_next = S_WB_R;
      S_EXEC_I: state_next = S_WB_I;
      S_ADDR:   state_next = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        if (mem.mem_ack)      state_next = S_WB_MEM;
        else if (timeout_hit) begin state_next = S_TRAP; cause_next = CAUSE_TIMEOUT; end
      end
      S_MEM_WR: begin
        if (mem.mem_ack)      state_next = S_FETCH;
        else if (timeout_hit) begin state_next = S_TRAP; cause_next = CAUSE_TIMEOUT; end
      end
      S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP: state_next = S_FETCH;
      S_TRAP:   state_next = S_TRAP;
      default:  state_next = S_TRAP;
    endcase
  end

  assign retire = (state_next == S_FETCH) &&
                  (state_reg inside {S_WB_R, S_WB_I, S_WB_MEM, S_MEM_WR, S_BRANCH, S_JUMP});

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_FETCH;
      ctl_reg       <= moore_ctl(S_FETCH, instr);
      wait_reg      <= '0;
      cause_reg     <= 2'd0;
      cycle_reg     <= '0;
      instr_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      ctl_reg   <= moore_ctl(state_next, instr);
      cycle_reg <= cycle_reg + 1'b1;
      if (retire) instr_cnt_reg <= instr_cnt_reg + 1'b1;
      if (state_next == S_TRAP && state_reg != S_TRAP) cause_reg <= cause_next;
      if (state_next != state_reg || mem.mem_ack) wait_reg <= '0;
      else if (ctl_reg.mem_req)                    wait_reg <= wait_reg + 1'b1;
    end
  end

  assign mem.mem_req = ctl_reg.mem_req & ~reset;
  assign mem.mem_we  = ctl_reg.mem_we;
  assign mem.iord    = ctl_reg.iord;

  assign ir_write = (state_reg == S_FETCH) && mem.mem_ack && !reset;

  always_comb begin
    pc_write = 1'b0;
    case (state_reg)
      S_FETCH:  pc_write = mem.mem_ack && !reset;
      S_BRANCH: pc_write = instr[26] ? !alu_zero : alu_zero;
      S_JUMP:   pc_write = 1'b1;
      default:  pc_write = 1'b0;
    endcase
  end

  assign pc_src      = ctl_reg.pc_src;
  assign alu_src_a   = ctl_reg.alu_src_a;
  assign alu_src_b   = ctl_reg.alu_src_b;
  assign alu_op      = ctl_reg.alu_op;
  assign ext_op      = ctl_reg.ext_op;
  assign reg_write   = ctl_reg.reg_write;
  assign reg_dst     = ctl_reg.reg_dst;
  assign mem_to_reg  = ctl_reg.mem_to_reg;
  assign state       = state_reg;
  assign trap        = (state_reg == S_TRAP);
  assign trap_cause  = cause_reg;
  assign cycle_count = cycle_reg;
  assign instr_count = instr_cnt_reg;

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: instruction sequences, memory waits, traps and resets.
module tb_mc_control;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        alu_zero;
  logic        ir_write, pc_write, alu_src_a, ext_op, reg_write, trap;
  logic [1:0]  pc_src, alu_src_b, reg_dst, mem_to_reg, trap_cause;
  logic [2:0]  alu_op;
  logic [3:0]  state;
  logic [31:0] cycle_count, instr_count;

  int n_cmp = 0;
  int n_err = 0;
  int cyc_n = 0;

  mc_control_if mif ();

  mc_control #(.CNT_W(32), .MEM_TIMEOUT(15), .TO_W(8)) dut (
    .clk(clk), .reset(reset), .instr(instr), .alu_zero(alu_zero), .mem(mif),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .ext_op(ext_op),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .state(state), .trap(trap), .trap_cause(trap_cause),
    .cycle_count(cycle_count), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; the bench keeps its own count of non-reset edges.
  task automatic cyc();
    @(posedge clk);
    if (!reset) cyc_n++;
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    #1;
    chk("rst_mem_req", 32'(mif.mem_req), 32'd0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_trap", 32'(trap), 32'd0);
    chk("rst_cause", 32'(trap_cause), 32'd0);
    chk("rst_cycles", cycle_count, 32'd0);
    chk("rst_instrs", instr_count, 32'd0);
    reset = 1'b0;
    cyc_n = 0;
  endtask

  initial begin
    reset = 1'b1; instr = 32'h00221820; alu_zero = 1'b0; mif.mem_ack = 1'b1;
    do_reset();

    // add r3,r1,r2 with ack tied high: 0,1,2,7,0
    #1;
    chk("add_f_state", 32'(state), 32'd0);
    chk("add_f_req", 32'(mif.mem_req), 32'd1);
    chk("add_f_irw", 32'(ir_write), 32'd1);
    chk("add_f_pcw", 32'(pc_write), 32'd1);
    chk("add_f_srcb", 32'(alu_src_b), 32'd1);
    cyc(); #1;
    chk("add_d_state", 32'(state), 32'd1);
    chk("add_d_srcb", 32'(alu_src_b), 32'd3);
    chk("add_d_ext", 32'(ext_op), 32'd1);
    chk("add_d_regw", 32'(reg_write), 32'd0);
    cyc(); #1;
    chk("add_x_state", 32'(state), 32'd2);
    chk("add_x_srca", 32'(alu_src_a), 32'd1);
    chk("add_x_srcb", 32'(alu_src_b), 32'd0);
    chk("add_x_op", 32'(alu_op), 32'd0);
    chk("add_x_regw", 32'(reg_write), 32'd0);
    cyc(); #1;
    chk("add_w_state", 32'(state), 32'd7);
    chk("add_w_regw", 32'(reg_write), 32'd1);
    chk("add_w_dst", 32'(reg_dst), 32'd1);
    chk("add_w_m2r", 32'(mem_to_reg), 32'd0);
    chk("add_w_icnt", instr_count, 32'd0);
    cyc(); #1;
    chk("add_end_state", 32'(state), 32'd0);
    chk("add_end_icnt", instr_count, 32'd1);
    chk("add_end_cyc", cycle_count, 32'd4);

    // lw r2,4(r1) with three wait cycles in FETCH and in MEM_RD
    instr = 32'h8C220004;
    for (int i = 0; i < 3; i++) begin
      mif.mem_ack = 1'b0; #1;
      chk("lw_fwait_state", 32'(state), 32'd0);
      chk("lw_fwait_req", 32'(mif.mem_req), 32'd1);
      chk("lw_fwait_irw", 32'(ir_write), 32'd0);
      cyc();
    end
    mif.mem_ack = 1'b1; #1;
    chk("lw_fack_irw", 32'(ir_write), 32'd1);
    cyc(); mif.mem_ack = 1'b0; #1;
    chk("lw_d_state", 32'(state), 32'd1);
    cyc(); #1;
    chk("lw_a_state", 32'(state), 32'd4);
    chk("lw_a_srcb", 32'(alu_src_b), 32'd2);
    cyc();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("lw_mwait_state", 32'(state), 32'd5);
      chk("lw_mwait_req", 32'(mif.mem_req), 32'd1);
      chk("lw_mwait_iord", 32'(mif.iord), 32'd1);
      chk("lw_mwait_we", 32'(mif.mem_we), 32'd0);
      cyc();
    end
    mif.mem_ack = 1'b1; #1;
    chk("lw_mack_state", 32'(state), 32'd5);
    cyc(); #1;
    chk("lw_wb_state", 32'(state), 32'd9);
    chk("lw_wb_regw", 32'(reg_write), 32'd1);
    chk("lw_wb_m2r", 32'(mem_to_reg), 32'd1);
    chk("lw_wb_dst", 32'(reg_dst), 32'd0);
    cyc(); #1;
    chk("lw_end_state", 32'(state), 32'd0);
    chk("lw_end_cyc", cycle_count, 32'd15);
    chk("lw_end_icnt", instr_count, 32'd2);

    // beq taken, then bne with the same zero flag (not taken)
    instr = 32'h10220003; alu_zero = 1'b1;
    cyc(); cyc(); #1;
    chk("beq_state", 32'(state), 32'd10);
    chk("beq_pcw", 32'(pc_write), 32'd1);
    chk("beq_pcsrc", 32'(pc_src), 32'd1);
    chk("beq_op", 32'(alu_op), 32'd1);
    cyc();
    instr = 32'h14220003;
    cyc(); cyc(); #1;
    chk("bne_state", 32'(state), 32'd10);
    chk("bne_z1_pcw", 32'(pc_write), 32'd0);
    alu_zero = 1'b0; #1;
    chk("bne_z0_pcw", 32'(pc_write), 32'd1);
    cyc(); #1;
    chk("br_icnt", instr_count, 32'd4);

    // jal then jr
    instr = 32'h0C000010;
    cyc(); cyc(); #1;
    chk("jal_state", 32'(state), 32'd11);
    chk("jal_pcw", 32'(pc_write), 32'd1);
    chk("jal_pcsrc", 32'(pc_src), 32'd2);
    chk("jal_regw", 32'(reg_write), 32'd1);
    chk("jal_dst", 32'(reg_dst), 32'd2);
    chk("jal_m2r", 32'(mem_to_reg), 32'd2);
    cyc();
    instr = 32'h03E00008;
    cyc(); cyc(); #1;
    chk("jr_state", 32'(state), 32'd11);
    chk("jr_pcsrc", 32'(pc_src), 32'd3);
    chk("jr_regw", 32'(reg_write), 32'd0);
    cyc(); #1;
    chk("jr_icnt", instr_count, 32'd6);

    // illegal opcode 0x3F traps after DECODE and idles with ack held high
    instr = 32'hFC000000;
    cyc(); cyc(); #1;
    chk("ill_state", 32'(state), 32'd15);
    chk("ill_trap", 32'(trap), 32'd1);
    chk("ill_cause", 32'(trap_cause), 32'd1);
    for (int i = 0; i < 20; i++) begin
      cyc(); #1;
      chk("ill_idle_req", 32'(mif.mem_req), 32'd0);
      chk("ill_idle_en", 32'({pc_write, ir_write, reg_write}), 32'd0);
    end
    chk("ill_state_held", 32'(state), 32'd15);
    chk("ill_cycles", cycle_count, 32'(cyc_n));
    chk("ill_icnt", instr_count, 32'd6);
    do_reset();

    // timeout: no ack, trap exactly 16 cycles after entering FETCH
    instr = 32'h00221820; mif.mem_ack = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("to_wait_state", 32'(state), 32'd0);
      cyc();
    end
    #1;
    chk("to_state", 32'(state), 32'd15);
    chk("to_cause", 32'(trap_cause), 32'd2);
    chk("to_req", 32'(mif.mem_req), 32'd0);
    do_reset();

    // ack on wait cycle 15 completes the fetch
    mif.mem_ack = 1'b0;
    for (int i = 0; i < 15; i++) cyc();
    mif.mem_ack = 1'b1; #1;
    chk("late_ack_irw", 32'(ir_write), 32'd1);
    cyc(); #1;
    chk("late_ack_state", 32'(state), 32'd1);
    chk("late_ack_trap", 32'(trap), 32'd0);
    do_reset();

    // reset mid-wait abandons the request and clears the wait counter
    mif.mem_ack = 1'b0;
    for (int i = 0; i < 8; i++) cyc();
    reset = 1'b1; #1;
    chk("midrst_req", 32'(mif.mem_req), 32'd0);
    do_reset();
    for (int i = 0; i < 15; i++) cyc();
    #1;
    chk("midrst_nowrap_state", 32'(state), 32'd0);
    chk("midrst_cycles", cycle_count, 32'd15);
    cyc(); #1;
    chk("midrst_to_state", 32'(state), 32'd15);
    chk("midrst_to_cause", 32'(trap_cause), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
